float_to_int: RTL and testbench

FLOAT_TO_INT -- requirements
Module: float_to_int

---
 rtl/fpu_pkg.sv | 17 +
 rtl/float_to_int.sv | 117 +++++++++++
 tb/tb_float_to_int.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: controller state encoding and IEEE-754 single constants
// used by the float/int converters and the divider.
package fpu_pkg;

  typedef enum logic [2:0] {
    GET_A   = 3'd0,
    UNPACK  = 3'd1,
    SPECIAL = 3'd2,
    CONVERT = 3'd3,
    SIGN    = 3'd4,
    PUT_Z   = 3'd5
  } state_t;

  localparam logic signed [9:0] EXP_BIAS = 10'sd127;
  localparam logic [31:0]       INT_MIN  = 32'h8000_0000;

endpackage

// File: rtl/float_to_int.sv
// IEEE-754 single to 32-bit signed integer converter, truncating toward zero,
// with stb/ack handshakes on both ports and a one-bit-per-cycle shifter.
//
// state   | meaning
// GET_A   | input_a_ack high, waiting for an operand
// UNPACK  | split sign, unbiased exponent and mantissa
// SPECIAL | |x|<1 -> 0, too large / Inf / NaN -> INT_MIN
// CONVERT | shift mantissa right until exponent reaches 31
// SIGN    | apply two's-complement negation
// PUT_Z   | output_z_stb high, waiting for output_z_ack
module float_to_int
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  e_q, e_d;
  logic [31:0]        v_q, v_d;
  logic [31:0]        z_d;
  logic               ack_d, stb_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= GET_A;
      a_q          <= '0;
      sign_q       <= 1'b0;
      e_q          <= '0;
      v_q          <= '0;
      output_z     <= '0;
      input_a_ack  <= 1'b0;
      output_z_stb <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      sign_q       <= sign_d;
      e_q          <= e_d;
      v_q          <= v_d;
      output_z     <= z_d;
      input_a_ack  <= ack_d;
      output_z_stb <= stb_d;
    end
  end

  // Handshake outputs are next-state values so they come straight from flops.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    sign_d  = sign_q;
    e_d     = e_q;
    v_d     = v_q;
    z_d     = output_z;
    ack_d   = 1'b0;
    stb_d   = 1'b0;
    case (state_q)
      GET_A: begin
        ack_d = 1'b1;
        if (input_a_ack && input_a_stb) begin
          a_d     = input_a;
          ack_d   = 1'b0;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        sign_d  = a_q[31];
        e_d     = $signed({2'b00, a_q[30:23]}) - EXP_BIAS;
        v_d     = {1'b1, a_q[22:0], 8'b0};
        state_d = SPECIAL;
      end
      SPECIAL: begin
        if (e_q < 10'sd0) begin
          z_d     = '0;
          stb_d   = 1'b1;
          state_d = PUT_Z;
        end else if (e_q > 10'sd30) begin
          z_d     = INT_MIN;
          stb_d   = 1'b1;
          state_d = PUT_Z;
        end else begin
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        if (e_q == 10'sd31) begin
          state_d = SIGN;
        end else begin
          v_d = v_q >> 1;
          e_d = e_q + 10'sd1;
        end
      end
      SIGN: begin
        z_d     = sign_q ? -v_q : v_q;
        stb_d   = 1'b1;
        state_d = PUT_Z;
      end
      PUT_Z: begin
        stb_d = 1'b1;
        if (output_z_ack) begin
          stb_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end

endmodule

// File: tb/tb_float_to_int.sv
// Self-checking bench for float_to_int: directed and randomized operands against
// an arithmetic reference, handshake timing, backpressure, reset and streaming.
module tb_float_to_int;

  logic        clk;
  logic        rst;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  int checks;
  int failures;

  float_to_int dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: value = 1.frac * 2^E, truncated toward zero, saturating to INT_MIN.
  function automatic logic [31:0] ref_conv(input logic [31:0] a);
    int          ex;
    logic [63:0] m;
    logic [63:0] mag;
    logic [31:0] r;
    ex = int'(a[30:23]) - 127;
    m  = {40'b0, 1'b1, a[22:0]};
    if (ex < 0) return 32'h0;
    if (ex > 30) return 32'h8000_0000;
    if (ex >= 23) mag = m << (ex - 23);
    else mag = m >> (23 - ex);
    r = mag[31:0];
    return a[31] ? -r : r;
  endfunction

  function automatic int ref_lat(input logic [31:0] a);
    int ex;
    ex = int'(a[30:23]) - 127;
    if (ex < 0 || ex > 30) return 2;
    return 35 - ex;
  endfunction

  // One full operation; returns result, latency, and handshake observations.
  task automatic do_op(input logic [31:0] a, input int hold,
                       output logic [31:0] z, output int lat,
                       output bit stable, output bit ack_quiet,
                       output logic stb_after, output logic ack_after);
    int n;
    n = 0;
    while (!input_a_ack && n < 100) begin
      @(posedge clk); #1; n++;
    end
    input_a     = a;
    input_a_stb = 1'b1;
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    input_a     = $urandom;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1; lat++;
      if (output_z_stb) break;
    end
    z         = output_z;
    stable    = 1'b1;
    ack_quiet = !input_a_ack;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (output_z !== z || output_z_stb !== 1'b1) stable = 1'b0;
      if (input_a_ack !== 1'b0) ack_quiet = 1'b0;
    end
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
    stb_after = output_z_stb;
    ack_after = input_a_ack;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++;
    if (input_a_ack !== 1'b0 || output_z_stb !== 1'b0 || output_z !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: ack=%b stb=%b z=%h, required 0 0 00000000",
               input_a_ack, output_z_stb, output_z);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (input_a_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_ack_early: ack=%b required 0", input_a_ack);
    end
    @(posedge clk); #1;
    checks++;
    if (input_a_ack !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ack: ack=%b required 1", input_a_ack);
    end
  endtask

  task automatic run_vec(input logic [31:0] a, input string name);
    logic [31:0] z;
    int          lat;
    bit          stable, quiet;
    logic        sa, aa;
    do_op(a, 0, z, lat, stable, quiet, sa, aa);
    checks++;
    if (z !== ref_conv(a)) begin
      failures++;
      $display("FAIL %s_value: in=%h got=%h required=%h", name, a, z, ref_conv(a));
    end
    checks++;
    if (lat !== ref_lat(a)) begin
      failures++;
      $display("FAIL %s_latency: in=%h got=%0d required=%0d", name, a, lat, ref_lat(a));
    end
    checks++;
    if (sa !== 1'b0 || aa !== 1'b1 || !quiet) begin
      failures++;
      $display("FAIL %s_handshake: stb_after=%b ack_after=%b ack_low_in_put=%b required 0 1 1",
               name, sa, aa, quiet);
    end
  endtask

  task automatic test_directed();
    logic [31:0] vecs [12];
    vecs = '{32'h3F80_0000, 32'hC020_0000, 32'h3F40_0000, 32'h7FC0_0000,
             32'h7F80_0000, 32'h4F00_0000, 32'hCF00_0000, 32'h4EFF_FFFF,
             32'h0000_0000, 32'h0000_0001, 32'hBF00_0000, 32'hCEFF_FFFF};
    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("dir%0d", i));
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 30; i++) begin
      if (i % 5 == 4) a = $urandom;
      else a = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 160)), 23'($urandom)};
      run_vec(a, $sformatf("rnd%0d", i));
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] z;
    int          lat;
    bit          stable, quiet;
    logic        sa, aa;
    do_op(32'hC0A0_0000, 20, z, lat, stable, quiet, sa, aa);
    checks++;
    if (z !== 32'hFFFF_FFFB) begin
      failures++;
      $display("FAIL bp_value: got=%h required=FFFFFFFB", z);
    end
    checks++;
    if (!stable || !quiet) begin
      failures++;
      $display("FAIL bp_hold: z_stable=%b ack_low=%b required 1 1", stable, quiet);
    end
    checks++;
    if (sa !== 1'b0 || aa !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: stb=%b ack=%b required 0 1", sa, aa);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] z;
    int          lat;
    bit          stable, quiet;
    logic        sa, aa;
    int          n;
    n = 0;
    while (!input_a_ack && n < 100) begin
      @(posedge clk); #1; n++;
    end
    input_a     = 32'h3F80_0000;
    input_a_stb = 1'b1;
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (input_a_ack !== 1'b0 || output_z_stb !== 1'b0 || output_z !== 32'h0) begin
      failures++;
      $display("FAIL midreset_outputs: ack=%b stb=%b z=%h required 0 0 00000000",
               input_a_ack, output_z_stb, output_z);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    do_op(32'h40E0_0000, 0, z, lat, stable, quiet, sa, aa);
    checks++;
    if (z !== 32'h0000_0007 || lat !== 33) begin
      failures++;
      $display("FAIL midreset_after: got=%h lat=%0d required 00000007 lat=33", z, lat);
    end
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (output_z_stb) n++;
    end
    checks++;
    if (n !== 0) begin
      failures++;
      $display("FAIL midreset_single: extra stb cycles=%0d required 0", n);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ops [$];
    logic [31:0] acc [$];
    logic [31:0] got [$];
    int          idx, overlap, tail;
    bit          tx_in;
    for (int i = 0; i < 8; i++)
      ops.push_back({1'($urandom_range(0, 1)), 8'($urandom_range(124, 160)), 23'($urandom)});
    idx = 0; overlap = 0; tail = 0;
    input_a      = ops[0];
    input_a_stb  = 1'b1;
    output_z_ack = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (input_a_ack && output_z_stb) overlap++;
      tx_in = input_a_ack && input_a_stb;
      if (tx_in) acc.push_back(input_a);
      if (output_z_stb) got.push_back(output_z);
      @(posedge clk); #1;
      if (tx_in) begin
        idx++;
        if (idx < ops.size()) input_a = ops[idx];
        else input_a_stb = 1'b0;
      end
      if (got.size() >= ops.size()) tail++;
      if (tail > 40) break;
    end
    input_a_stb  = 1'b0;
    output_z_ack = 1'b0;
    checks++;
    if (acc.size() !== ops.size() || got.size() !== ops.size()) begin
      failures++;
      $display("FAIL b2b_counts: accepted=%0d results=%0d required %0d",
               acc.size(), got.size(), ops.size());
    end
    checks++;
    if (overlap !== 0) begin
      failures++;
      $display("FAIL b2b_overlap: cycles with ack and stb both high=%0d required 0", overlap);
    end
    for (int i = 0; i < ops.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== ref_conv(ops[i])) begin
        failures++;
        $display("FAIL b2b_result%0d: in=%h got=%h required=%h", i, ops[i], got[i], ref_conv(ops[i]));
      end
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    input_a      = '0;
    input_a_stb  = 1'b0;
    output_z_ack = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
